bram_sd_ctrl: RTL and testbench
===============================

Name: bram_sd_ctrl

Overview:
- Multi-slot backup-RAM save/load sequencer between the SD sector interface of hps_io and the cartridge backup RAM port in the system core.
- Parametrised successor of the single-slot, fixed-128-sector save/load logic in the top-level emu.
- Adds: slot selection, image-size-clamped loads, ack timeout with error reporting, abort on new ROM download, and an autosave policy.
- The backup RAM port address is formed externally as {sd_lba[SEC_W-1:0], sd_buff_addr}.

Parameters:
SECTORS, 128, 512-byte sectors per save slot (power of two, at least 2)
SLOTS, 4, number of save slots in one image (power of two, at least 1)
TIMEOUT, 24'd10000000, clk_sys cycles allowed between sd_rd/sd_wr assertion and rising sd_ack

Ports:
clk_sys in 1: system clock
reset_n in 1: asynchronous active-low reset
downloading in 1: ROM download in progress (ioctl_download)
img_mounted in 1: save image mount strobe
img_readonly in 1: mounted image is read-only
img_size in 64: image size in bytes
slot in $clog2(SLOTS) (min 1): selected slot, sampled at transfer start
load_req in 1: manual load request (level; rising edge acts)
save_req in 1: manual save request (level; rising edge acts)
autosave_en in 1: autosave enable from OSD
osd_open in 1: OSD visible (OSD_STATUS)
bram_change in 1: backup RAM written by the core
sd_ack in 1: sector transfer acknowledge
sd_lba out 32: sector address
sd_rd out 1: sector read request
sd_wr out 1: sector write request
bk_ena out 1: save image usable
loading out 1: load in progress; top level ORs this into core reset
busy out 1: any transfer in progress
sav_pending out 1: unsaved changes exist
error out 1: one-cycle pulse on timeout or an out-of-range load
done out 1: one-cycle pulse on successful completion

Behaviour:
- Reset values: all outputs are 0; state is IDLE; edge detectors clear.
- Constants:
  - SEC_W = $clog2(SECTORS)
  - base = slot*SECTORS
  - avail = img_size[40:9] (whole sectors in image)
- bk_ena:
  - Cleared on the rising edge of downloading.
  - Set when downloading & img_mounted & ~img_readonly.
- sav_pending:
  - Set when bram_change & ~osd_open.
  - Cleared in the cycle a SAVE transfer starts.
  - bram_change in that same cycle wins, and the flag stays set.
- Start conditions, evaluated in IDLE only, first match wins:
  1. Falling edge of downloading with bk_ena & avail != 0 -> LOAD.
  2. Rising edge of load_req with bk_ena -> LOAD.
  3. Rising edge of save_req with bk_ena -> SAVE.
  4. autosave_en & osd_open & sav_pending & bk_ena -> SAVE.
- Request edges seen while busy are discarded, not queued.
- LOAD range check:
  - If avail <= base: no transfer, error pulses, state stays IDLE.
  - Otherwise the count is min(SECTORS, avail - base).
- SAVE always transfers SECTORS sectors.
- On start:
  - sd_lba <= base; cnt <= count-1.
  - Assert sd_rd (LOAD) or sd_wr (SAVE).
  - busy <= 1; loading <= (LOAD).
- States:
  - IDLE: evaluate start conditions as above.
  - REQ:
    - Rising sd_ack clears sd_rd and sd_wr and moves to XFER.
    - The timer counts every cycle; reaching TIMEOUT goes to ERR.
  - XFER:
    - Falling sd_ack ends the sector.
    - If cnt == 0 go to FIN.
    - Otherwise sd_lba+1, cnt-1, reassert the request, return to REQ, and reset the timer.
  - FIN: done pulse; busy and loading drop; go to IDLE.
  - ERR: error pulse; drop sd_rd, sd_wr, busy, loading; go to IDLE; sd_lba holds its value.
- Edge detection on sd_ack uses a one-cycle registered copy, so request release lags ack by one cycle.
- A rising edge of downloading in any non-IDLE state aborts the transfer:
  - Drop sd_rd and sd_wr; clear busy and loading; no done or error pulse; go to IDLE.
  - bk_ena is cleared in the same cycle.
- A rising and falling sd_ack within one sampled cycle is not supported; sd_ack is held for at least 2 cycles by hps_io.
- sd_lba arithmetic is 32-bit and cannot wrap within a slot.

Decomposition:
- Package bram_sd_pkg holds:
  - the state enum (IDLE, REQ, XFER, FIN, ERR);
  - the transfer-kind enum (LOAD, SAVE);
  - localparam SECTOR_BYTES_LOG2 = 9.
- One sub-module, edge_det: a registered rising/falling edge pulse generator.
  - Instantiated for downloading, load_req, save_req and sd_ack.

Test Plan:
- Download 1->0 with an image mounted (img_size=65536, slot=0) -> loading=1 and sd_rd pulses for lba 0..127, each released 1 cycle after ack rises; then done pulses and loading=0.
- slot=2 with save_req rise, 2-cycle acks -> sd_wr covers lba 256..383; sav_pending clears at start; done pulses once after 128 sectors.
- img_size=(128*3+10)*512, slot=3 with load_req -> exactly 10 sectors (lba 384..393), then done; slot=3 with img_size=131072 -> error pulse and no sd_rd.
- bram_change with osd_open=0, then osd_open=1 and autosave_en=1 -> SAVE starts automatically; with autosave_en=0 no transfer and sav_pending stays 1.
- Ack never returned (TIMEOUT=100 in sim) -> error pulses at cycle 100 after request; sd_rd=0, busy=0, and a following load_req restarts the transfer.
- downloading rises during sector 5 of a load -> sd_rd=0, loading=0, busy=0, bk_ena=0 in the next cycle, with no done or error pulse.

Source files
------------

// File: rtl/bram_sd_pkg.sv
// Shared types for the backup-RAM save/load sequencer: FSM states, transfer kind
// and sector geometry.
package bram_sd_pkg;

   localparam int SECTOR_BYTES_LOG2 = 9;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      XFER,
      FIN,
      ERR
   } state_t;

   typedef enum logic {
      LOAD,
      SAVE
   } kind_t;

endpackage

// File: rtl/edge_det.sv
// Rising/falling edge pulses of a synchronous level, derived from a one-cycle
// registered copy so the pulse coincides with the first cycle of the new level.
module edge_det (
   input  logic clk_sys,
   input  logic reset_n,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic d_q;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         d_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignment so every flop samples pre-edge values.
         d_q <= d;
      end
   end

   assign rise = d & ~d_q;
   assign fall = ~d & d_q;

endmodule

// File: rtl/bram_sd_ctrl.sv
// Multi-slot backup-RAM save/load sequencer between the hps_io SD sector
// interface and the cartridge backup RAM; RAM address is {sd_lba[SEC_W-1:0], sd_buff_addr}.
module bram_sd_ctrl
   import bram_sd_pkg::*;
#(
   parameter int          SECTORS = 128,
   parameter int          SLOTS   = 4,
   parameter logic [23:0] TIMEOUT = 24'd10000000,
   localparam int         SEC_W   = $clog2(SECTORS),
   localparam int         SLOT_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              downloading,
   input  logic              img_mounted,
   input  logic              img_readonly,
   input  logic [63:0]       img_size,
   input  logic [SLOT_W-1:0] slot,
   input  logic              load_req,
   input  logic              save_req,
   input  logic              autosave_en,
   input  logic              osd_open,
   input  logic              bram_change,
   input  logic              sd_ack,
   output logic [31:0]       sd_lba,
   output logic              sd_rd,
   output logic              sd_wr,
   output logic              bk_ena,
   output logic              loading,
   output logic              busy,
   output logic              sav_pending,
   output logic              error,
   output logic              done
);

   state_t           state;
   kind_t            kind;
   logic [SEC_W-1:0] cnt;
   logic [23:0]      timer;

   logic dl_rise, dl_fall;
   logic ld_rise, sv_rise;
   logic ack_rise, ack_fall;
   logic unused_ld_fall, unused_sv_fall;

   edge_det u_dl_edge (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .d       (downloading),
      .rise    (dl_rise),
      .fall    (dl_fall)
   );

   edge_det u_ld_edge (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .d       (load_req),
      .rise    (ld_rise),
      .fall    (unused_ld_fall)
   );

   edge_det u_sv_edge (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .d       (save_req),
      .rise    (sv_rise),
      .fall    (unused_sv_fall)
   );

   edge_det u_ack_edge (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .d       (sd_ack),
      .rise    (ack_rise),
      .fall    (ack_fall)
   );

   // Only whole sectors inside the low 41 bits of the image size matter.
   logic [31:0] avail;
   logic        unused_img_bits;

   assign avail           = img_size[SECTOR_BYTES_LOG2 +: 32];
   assign unused_img_bits = ^{img_size[63:SECTOR_BYTES_LOG2+32], img_size[SECTOR_BYTES_LOG2-1:0]};

   logic [31:0]      base;
   logic [31:0]      remain;
   logic [SEC_W-1:0] load_last;
   logic [SEC_W-1:0] start_last;
   logic             start_load;
   logic             start_save;
   logic             range_err;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      base       = '0;
      remain     = '0;
      load_last  = '0;
      start_load = 1'b0;
      start_save = 1'b0;
      range_err  = 1'b0;

      if (SLOTS > 1) begin
         base = 32'(slot) << SEC_W;
      end
      remain = avail - base;

      // A slot cut short by a small image loads only the sectors that exist.
      if (remain >= 32'(SECTORS)) begin
         load_last = SEC_W'(SECTORS - 1);
      end else begin
         load_last = SEC_W'(remain - 32'd1);
      end

      if (state == IDLE && bk_ena) begin
         if ((dl_fall && avail != 32'd0) || ld_rise) begin
            if (avail > base) begin
               start_load = 1'b1;
            end else begin
               range_err = 1'b1;
            end
         end else if (sv_rise || (autosave_en && osd_open && sav_pending)) begin
            start_save = 1'b1;
         end
      end

      start_last = start_load ? load_last : SEC_W'(SECTORS - 1);
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         bk_ena <= 1'b0;
      end else if (downloading && img_mounted && !img_readonly) begin
         bk_ena <= 1'b1;
      end else if (dl_rise) begin
         bk_ena <= 1'b0;
      end
   end

   // A write landing in the same cycle a save starts must survive for the next save.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         sav_pending <= 1'b0;
      end else if (bram_change && !osd_open) begin
         sav_pending <= 1'b1;
      end else if (start_save) begin
         sav_pending <= 1'b0;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         kind    <= LOAD;
         cnt     <= '0;
         timer   <= '0;
         sd_lba  <= '0;
         sd_rd   <= 1'b0;
         sd_wr   <= 1'b0;
         busy    <= 1'b0;
         loading <= 1'b0;
         error   <= 1'b0;
         done    <= 1'b0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;

         if (state != IDLE && dl_rise) begin
            // A new ROM invalidates whatever was in flight; exit silently.
            sd_rd   <= 1'b0;
            sd_wr   <= 1'b0;
            busy    <= 1'b0;
            loading <= 1'b0;
            state   <= IDLE;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start_load || start_save) begin
                     sd_lba  <= base;
                     cnt     <= start_last;
                     kind    <= start_load ? LOAD : SAVE;
                     sd_rd   <= start_load;
                     sd_wr   <= start_save;
                     busy    <= 1'b1;
                     loading <= start_load;
                     timer   <= '0;
                     state   <= REQ;
                  end else if (range_err) begin
                     error <= 1'b1;
                  end
               end

               REQ: begin
                  if (ack_rise) begin
                     sd_rd <= 1'b0;
                     sd_wr <= 1'b0;
                     state <= XFER;
                  end else if (timer == TIMEOUT - 24'd1) begin
                     error   <= 1'b1;
                     sd_rd   <= 1'b0;
                     sd_wr   <= 1'b0;
                     busy    <= 1'b0;
                     loading <= 1'b0;
                     state   <= ERR;
                  end else begin
                     timer <= timer + 24'd1;
                  end
               end

               XFER: begin
                  if (ack_fall) begin
                     if (cnt == '0) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        loading <= 1'b0;
                        state   <= FIN;
                     end else begin
                        sd_lba <= sd_lba + 32'd1;
                        cnt    <= cnt - SEC_W'(1);
                        sd_rd  <= (kind == LOAD);
                        sd_wr  <= (kind == SAVE);
                        timer  <= '0;
                        state  <= REQ;
                     end
                  end
               end

               FIN:     state <= IDLE;
               ERR:     state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bram_sd_ctrl.sv
// Directed bench for bram_sd_ctrl: a vector table for flag/start behaviour plus
// hand-written transfer sequences with an sd_ack responder.
module tb_bram_sd_ctrl;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        downloading, img_mounted, img_readonly;
   logic [63:0] img_size;
   logic [1:0]  slot;
   logic        load_req, save_req, autosave_en, osd_open, bram_change, sd_ack;
   logic [31:0] sd_lba;
   logic        sd_rd, sd_wr, bk_ena, loading, busy, sav_pending, error, done;

   int total = 0;
   int bad   = 0;

   always #5 clk_sys = ~clk_sys;

   bram_sd_ctrl #(
      .SECTORS (128),
      .SLOTS   (4),
      .TIMEOUT (24'd100)
   ) dut (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .downloading  (downloading),
      .img_mounted  (img_mounted),
      .img_readonly (img_readonly),
      .img_size     (img_size),
      .slot         (slot),
      .load_req     (load_req),
      .save_req     (save_req),
      .autosave_en  (autosave_en),
      .osd_open     (osd_open),
      .bram_change  (bram_change),
      .sd_ack       (sd_ack),
      .sd_lba       (sd_lba),
      .sd_rd        (sd_rd),
      .sd_wr        (sd_wr),
      .bk_ena       (bk_ena),
      .loading      (loading),
      .busy         (busy),
      .sav_pending  (sav_pending),
      .error        (error),
      .done         (done)
   );

   typedef struct {
      logic        dl, mnt, ro, bch, osd, ld;
      logic [63:0] sz;
      logic [1:0]  sl;
      logic        bk, sp, err, bsy, rd;
   } vec_t;

   vec_t vecs [15];

   function automatic vec_t mk(input logic dl, mnt, ro, bch, osd, ld,
                               input logic [63:0] sz, input logic [1:0] sl,
                               input logic bk, sp, err, bsy, rd);
      vec_t v;
      v.dl = dl; v.mnt = mnt; v.ro = ro; v.bch = bch; v.osd = osd; v.ld = ld;
      v.sz = sz; v.sl = sl;
      v.bk = bk; v.sp = sp; v.err = err; v.bsy = bsy; v.rd = rd;
      return v;
   endfunction

   task automatic cyc();
      @(negedge clk_sys);
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
      end
   endtask

   // Host side of the sector handshake: answer n requests starting at lba0.
   task automatic serve(input bit wr, input logic [31:0] lba0, input int n,
                        input int hold, input string tag);
      for (int i = 0; i < n; i++) begin
         int w = 0;
         while ((wr ? sd_wr : sd_rd) !== 1'b1 && w < 20) begin
            cyc();
            w++;
         end
         check($sformatf("%s req%0d seen", tag, i), {63'd0, w < 20}, 64'd1);
         if (w >= 20) return;
         check($sformatf("%s req%0d lba", tag, i), sd_lba, lba0 + i);
         check($sformatf("%s req%0d other dir", tag, i), wr ? sd_rd : sd_wr, 1'b0);
         sd_ack = 1'b1;
         cyc();
         check($sformatf("%s req%0d released", tag, i), wr ? sd_wr : sd_rd, 1'b0);
         for (int h = 1; h < hold; h++) cyc();
         sd_ack = 1'b0;
         cyc();
      end
   endtask

   task automatic check_done(input string tag);
      check({tag, " done"}, done, 1'b1);
      check({tag, " busy end"}, busy, 1'b0);
      check({tag, " loading end"}, loading, 1'b0);
      cyc();
      check({tag, " done single"}, done, 1'b0);
   endtask

   initial begin
      int  k;
      bit  seen;

      reset_n = 1'b0;
      downloading = 0; img_mounted = 0; img_readonly = 0; img_size = '0; slot = '0;
      load_req = 0; save_req = 0; autosave_en = 0; osd_open = 0; bram_change = 0; sd_ack = 0;

      vecs[0]  = mk(0,0,0,0,0,0, 64'd0,      2'd0, 0,0,0,0,0);
      vecs[1]  = mk(1,0,0,0,0,0, 64'd0,      2'd0, 0,0,0,0,0);
      vecs[2]  = mk(1,1,1,0,0,0, 64'd0,      2'd0, 0,0,0,0,0);
      vecs[3]  = mk(1,1,0,0,0,0, 64'd0,      2'd0, 1,0,0,0,0);
      vecs[4]  = mk(1,0,0,0,0,0, 64'd0,      2'd0, 1,0,0,0,0);
      vecs[5]  = mk(1,0,0,1,0,0, 64'd0,      2'd0, 1,1,0,0,0);
      vecs[6]  = mk(1,0,0,1,1,0, 64'd0,      2'd0, 1,1,0,0,0);
      vecs[7]  = mk(0,0,0,0,0,0, 64'd0,      2'd0, 1,1,0,0,0);
      vecs[8]  = mk(0,0,0,0,0,1, 64'd131072, 2'd3, 1,1,1,0,0);
      vecs[9]  = mk(0,0,0,0,0,1, 64'd131072, 2'd3, 1,1,0,0,0);
      vecs[10] = mk(0,0,0,0,0,0, 64'd65536,  2'd0, 1,1,0,0,0);
      vecs[11] = mk(1,0,0,0,0,0, 64'd65536,  2'd0, 0,1,0,0,0);
      vecs[12] = mk(0,0,0,0,0,0, 64'd65536,  2'd0, 0,1,0,0,0);
      vecs[13] = mk(0,0,0,0,0,1, 64'd65536,  2'd0, 0,1,0,0,0);
      vecs[14] = mk(0,0,0,0,0,0, 64'd65536,  2'd0, 0,1,0,0,0);

      repeat (3) cyc();
      check("reset outputs", {sd_lba, sd_rd, sd_wr, bk_ena, loading, busy, sav_pending, error, done}, 64'd0);
      reset_n = 1'b1;
      cyc();
      check("after reset outputs", {sd_lba, sd_rd, sd_wr, bk_ena, loading, busy, sav_pending, error, done}, 64'd0);

      for (int i = 0; i < 15; i++) begin
         downloading = vecs[i].dl; img_mounted = vecs[i].mnt; img_readonly = vecs[i].ro;
         bram_change = vecs[i].bch; osd_open = vecs[i].osd; load_req = vecs[i].ld;
         img_size = vecs[i].sz; slot = vecs[i].sl;
         cyc();
         check($sformatf("vec%0d bk_ena", i), bk_ena, vecs[i].bk);
         check($sformatf("vec%0d sav_pending", i), sav_pending, vecs[i].sp);
         check($sformatf("vec%0d error", i), error, vecs[i].err);
         check($sformatf("vec%0d busy", i), busy, vecs[i].bsy);
         check($sformatf("vec%0d sd_rd", i), sd_rd, vecs[i].rd);
      end
      img_mounted = 0; bram_change = 0; osd_open = 0; load_req = 0;

      // Load after ROM download, slot 0, full 128 sectors.
      downloading = 1; cyc();
      img_mounted = 1; img_size = 64'd65536; slot = 2'd0; cyc();
      img_mounted = 0;
      check("dl bk_ena", bk_ena, 1'b1);
      downloading = 0; cyc();
      check("dl loading", loading, 1'b1);
      check("dl busy", busy, 1'b1);
      check("dl sd_rd", sd_rd, 1'b1);
      serve(1'b0, 32'd0, 128, 2, "dl_load");
      check_done("dl_load");

      // Manual save to slot 2 clears the pending flag at start.
      slot = 2'd2; save_req = 1; cyc();
      check("save sd_wr", sd_wr, 1'b1);
      check("save sav_pending", sav_pending, 1'b0);
      check("save loading", loading, 1'b0);
      serve(1'b1, 32'd256, 128, 2, "save2");
      check_done("save2");
      save_req = 0;
      bram_change = 1; osd_open = 1; cyc();
      bram_change = 0; cyc();
      check("change with osd open", sav_pending, 1'b0);
      osd_open = 0;

      // Image truncated inside slot 3: exactly 10 sectors.
      slot = 2'd3; img_size = 64'((128 * 3 + 10) * 512); load_req = 1; cyc();
      check("short sd_rd", sd_rd, 1'b1);
      check("short loading", loading, 1'b1);
      serve(1'b0, 32'd384, 10, 3, "short");
      check_done("short");
      check("short no 11th", sd_rd, 1'b0);
      load_req = 0; cyc();
      img_size = 64'd131072; load_req = 1; cyc();
      check("range error", error, 1'b1);
      check("range sd_rd", sd_rd, 1'b0);
      check("range busy", busy, 1'b0);
      cyc();
      check("range error single", error, 1'b0);
      load_req = 0;

      // Autosave only when enabled and the OSD is open.
      bram_change = 1; cyc();
      bram_change = 0; osd_open = 1; cyc();
      check("pending set", sav_pending, 1'b1);
      repeat (3) cyc();
      check("no autosave busy", busy, 1'b0);
      check("no autosave pending", sav_pending, 1'b1);
      autosave_en = 1; cyc();
      check("autosave sd_wr", sd_wr, 1'b1);
      check("autosave pending", sav_pending, 1'b0);
      serve(1'b1, 32'd384, 128, 2, "autosave");
      check_done("autosave");
      autosave_en = 0; osd_open = 0;

      // Write landing in the save-start cycle keeps the flag set.
      slot = 2'd1; save_req = 1; bram_change = 1; cyc();
      bram_change = 0;
      check("coinc sd_wr", sd_wr, 1'b1);
      check("coinc pending", sav_pending, 1'b1);
      serve(1'b1, 32'd128, 128, 2, "coinc");
      check_done("coinc");
      save_req = 0;

      // Ack never returned: timeout after 100 cycles, then a clean restart.
      slot = 2'd0; img_size = 64'd65536; load_req = 1; cyc();
      load_req = 0;
      check("to sd_rd", sd_rd, 1'b1);
      k = 1;
      while (k <= 150) begin
         cyc();
         if (error === 1'b1) break;
         k++;
      end
      check("timeout cycle", k, 100);
      check("timeout sd_rd", sd_rd, 1'b0);
      check("timeout busy", busy, 1'b0);
      check("timeout loading", loading, 1'b0);
      check("timeout lba", sd_lba, 32'd0);
      cyc();
      check("timeout error single", error, 1'b0);
      load_req = 1; cyc();
      check("restart sd_rd", sd_rd, 1'b1);
      check("restart busy", busy, 1'b1);
      serve(1'b0, 32'd0, 5, 2, "restart");

      // New ROM download during sector 5 aborts silently.
      check("abort lba", sd_lba, 32'd5);
      check("abort pre sd_rd", sd_rd, 1'b1);
      sd_ack = 1; cyc();
      downloading = 1; cyc();
      check("abort sd_rd", sd_rd, 1'b0);
      check("abort sd_wr", sd_wr, 1'b0);
      check("abort loading", loading, 1'b0);
      check("abort busy", busy, 1'b0);
      check("abort bk_ena", bk_ena, 1'b0);
      seen = done | error;
      sd_ack = 0;
      repeat (4) begin
         cyc();
         seen |= done | error | sd_rd;
      end
      check("abort quiet", seen, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
